// File: rtl/phase_sequencer_ctrl_if.sv
// Control bundle between the sequencer and the 16-bit core datapath.
// master = core/bench side, slave = phase_sequencer_ctrl.
interface phase_sequencer_ctrl_if;
   logic        run;
   logic        step;
   logic        mem_rdy;
   logic [15:0] instruction;
   logic        S;
   logic        Z;
   logic        C;
   logic        V;
   logic [2:0]  phase;
   logic        halted;
   logic        busy;
   logic        illegal;
   logic [5:0]  alu_instruction;
   logic [19:0] ctrl;

   modport master (
      output run, step, mem_rdy, instruction, S, Z, C, V,
      input  phase, halted, busy, illegal, alu_instruction, ctrl
   );

   modport slave (
      input  run, step, mem_rdy, instruction, S, Z, C, V,
      output phase, halted, busy, illegal, alu_instruction, ctrl
   );
endinterface

// File: rtl/phase_sequencer_ctrl.sv
// Phase counter, run/step/halt FSM, memory wait and branch latch
// for the multi-cycle 16-bit core; emits phase-gated enables.
module phase_sequencer_ctrl #(
   parameter int NUM_PHASES = 5,
   parameter int MEM_PHASE  = 3,
   parameter bit WAIT_EN    = 1'b1
) (
   input logic                   clk,
   input logic                   rst,
   phase_sequencer_ctrl_if.slave bus
);
   localparam logic [2:0] WB = 3'(NUM_PHASES - 1);
   localparam logic [2:0] MP = 3'(MEM_PHASE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_WAIT,
      S_HALT
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] phase_q, phase_d;
   logic       taken_q, taken_d;
   logic       step_mode_q, step_mode_d;

   logic [1:0] op;
   logic [2:0] r1, r2;
   logic [3:0] aop;

   assign op  = bus.instruction[15:14];
   assign r1  = bus.instruction[13:11];
   assign r2  = bus.instruction[10:8];
   assign aop = bus.instruction[7:4];

   logic c_alu, c_cmp, c_mov, c_shift, c_in, c_out, c_hlt;
   logic c_ld, c_st, c_li, c_b, c_bc, c_br, c_legal;

   assign c_alu   = (op == 2'b11) && (aop <= 4'd4);
   assign c_cmp   = (op == 2'b11) && (aop == 4'd5);
   assign c_mov   = (op == 2'b11) && (aop == 4'd6);
   assign c_shift = (op == 2'b11) && (aop[3:2] == 2'b10);
   assign c_in    = (op == 2'b11) && (aop == 4'd12);
   assign c_out   = (op == 2'b11) && (aop == 4'd13);
   assign c_hlt   = (op == 2'b11) && (aop == 4'd15);
   assign c_ld    = (op == 2'b00);
   assign c_st    = (op == 2'b01);
   assign c_li    = (op == 2'b10) && (r1 == 3'd0);
   assign c_b     = (op == 2'b10) && (r1 == 3'd4);
   assign c_bc    = (op == 2'b10) && (r1 == 3'd7) && !r2[2];
   assign c_br    = c_b || c_bc;
   assign c_legal = c_alu || c_cmp || c_mov || c_shift || c_in
                 || c_out || c_hlt || c_ld || c_st || c_li || c_br;

   logic cond;
   always_comb begin
      cond = 1'b0;
      if (c_b) begin
         cond = 1'b1;
      end else if (c_bc) begin
         unique case (r2[1:0])
            2'd0:    cond = bus.Z;
            2'd1:    cond = bus.S ^ bus.V;
            2'd2:    cond = bus.Z | (bus.S ^ bus.V);
            default: cond = ~bus.Z;
         endcase
      end
   end

   // WAIT keeps the MEM_PHASE enables alive, so it gates like RUN
   logic active, p0, p1, p2, pm, pwb, held;
   assign active = (state_q == S_RUN) || (state_q == S_WAIT);
   assign p0     = active && (phase_q == 3'd0);
   assign p1     = active && (phase_q == 3'd1);
   assign p2     = active && (phase_q == 3'd2);
   assign pm     = active && (phase_q == MP);
   assign pwb    = active && (phase_q == WB);
   assign held   = active && (phase_q != 3'd0);

   logic aluc_e, ar_e, br_e, dr_e, mdr_e, ir_e, reg_e, genr_w;
   logic mem_e, mem_w, jump, out_s;
   logic m2_s, m3_s, m4_s, m5_s, m6_s, m7_s, m8_s;

   assign ir_e   = p0;
   assign ar_e   = p1 && (c_alu || c_cmp || c_st || c_out || c_br);
   assign br_e   = p1 && (c_alu || c_cmp || c_shift || c_ld || c_st || c_br);
   assign aluc_e = p2 && (c_alu || c_cmp || c_mov || c_shift
                       || c_ld || c_st || c_br);
   assign dr_e   = p2 && (c_alu || c_shift || c_ld || c_st || c_br);
   assign mem_e  = pm && (c_ld || c_st || c_in);
   assign mem_w  = pm && c_st;
   assign mdr_e  = pm && (c_ld || c_in);
   assign genr_w = pwb && (c_alu || c_mov || c_shift || c_in || c_ld || c_li);
   assign reg_e  = pwb && c_legal && !c_hlt;
   assign out_s  = pwb && c_out;
   assign jump   = pwb && taken_q;
   assign m2_s   = held && (c_shift || c_ld || c_st || c_br);
   assign m3_s   = held && c_br;
   assign m4_s   = held && (c_ld || c_in);
   assign m5_s   = held && (c_alu || c_mov || c_shift || c_in || c_li);
   assign m6_s   = held && c_st;
   assign m7_s   = held && c_in;
   assign m8_s   = held && c_li;

   // Bit 19 is a spare, tied low
   assign bus.ctrl = {1'b0, aluc_e, ar_e, br_e, dr_e, mdr_e, ir_e, reg_e,
                      genr_w, mem_e, mem_w, jump, m2_s, m3_s, m4_s,
                      m5_s, m6_s, m7_s, m8_s, out_s};

   assign bus.phase   = phase_q;
   assign bus.halted  = (state_q == S_HALT);
   assign bus.busy    = active;
   assign bus.illegal = (state_q == S_RUN) && (phase_q == WB) && !c_legal;
   assign bus.alu_instruction = (op == 2'b11) ? {op, aop}
                                              : bus.instruction[15:10];

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      taken_d     = taken_q;
      step_mode_d = step_mode_q;
      unique case (state_q)
         S_IDLE: begin
            phase_d = 3'd0;
            taken_d = 1'b0;
            if (bus.run || bus.step) begin
               state_d     = S_RUN;
               step_mode_d = bus.step && !bus.run;
            end
         end
         S_RUN: begin
            if (phase_q == WB) begin
               phase_d = 3'd0;
               taken_d = 1'b0;
               if (c_hlt)
                  state_d = S_HALT;
               else if (step_mode_q || !bus.run)
                  state_d = S_IDLE;
            end else if (WAIT_EN && mem_e && !bus.mem_rdy) begin
               state_d = S_WAIT;
            end else begin
               phase_d = phase_q + 3'd1;
               if (phase_q == WB - 3'd1)
                  taken_d = cond;
            end
         end
         S_WAIT: begin
            if (bus.mem_rdy) begin
               state_d = S_RUN;
               phase_d = MP + 3'd1;
               if (MP == WB - 3'd1)
                  taken_d = cond;
            end
         end
         default: begin
            phase_d = 3'd0;
            taken_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         phase_q     <= 3'd0;
         taken_q     <= 1'b0;
         step_mode_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         taken_q     <= taken_d;
         step_mode_q <= step_mode_d;
      end
   end
endmodule

// File: tb/tb_phase_sequencer_ctrl.sv
// Directed and random bench for phase_sequencer_ctrl against a
// class/phase-table reference model.
module tb_phase_sequencer_ctrl;
   localparam int NP = 5;
   localparam int MP = 3;
   localparam int WB = NP - 1;

   localparam int K_ALU = 0, K_CMP = 1, K_MOV = 2, K_SHIFT = 3;
   localparam int K_IN = 4, K_OUT = 5, K_HLT = 6, K_LD = 7;
   localparam int K_ST = 8, K_LI = 9, K_B = 10, K_BE = 11;
   localparam int K_BLT = 12, K_BLE = 13, K_BNE = 14, K_ILL = 15;

   localparam int B_REG_E = 12, B_GENR_W = 11, B_MEM_E = 10;
   localparam int B_MDR_E = 14, B_JUMP = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   phase_sequencer_ctrl_if bus ();

   phase_sequencer_ctrl #(
      .NUM_PHASES (NP),
      .MEM_PHASE  (MP),
      .WAIT_EN    (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   bit m_ok = 0;
   bit m_busy, m_wait, m_halt, m_stepm, m_taken;
   int m_ph;

   function automatic int cls_of(logic [15:0] ir);
      int tab [16];
      tab = '{K_ALU, K_ALU, K_ALU, K_ALU, K_ALU, K_CMP, K_MOV, K_ILL,
              K_SHIFT, K_SHIFT, K_SHIFT, K_SHIFT, K_IN, K_OUT, K_ILL, K_HLT};
      case (ir[15:14])
         2'b00: return K_LD;
         2'b01: return K_ST;
         2'b11: return tab[ir[7:4]];
         default: begin
            if (ir[13:11] == 3'd0) return K_LI;
            if (ir[13:11] == 3'd4) return K_B;
            if (ir[13:11] == 3'd7 && ir[10:8] < 3'd4)
               return K_BE + int'(ir[10:8]);
            return K_ILL;
         end
      endcase
   endfunction

   function automatic bit cond_of(int c);
      bit sv;
      sv = bus.S ^ bus.V;
      case (c)
         K_B:   return 1'b1;
         K_BE:  return bus.Z;
         K_BLT: return sv;
         K_BLE: return bus.Z | sv;
         K_BNE: return !bus.Z;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [19:0] exp_ctrl(int c);
      bit br, on, h;
      bit aluc, ar, bre, dr, mdr, ire, rege, gw, me, mw, jmp, os;
      bit s2, s3, s4, s5, s6, s7, s8;
      on = m_busy && !m_halt;
      if (!on) return 20'd0;
      br = (c >= K_B) && (c <= K_BNE);
      h = m_ph != 0;
      ire  = m_ph == 0;
      ar   = m_ph == 1 && (c == K_ALU || c == K_CMP || c == K_ST
                           || c == K_OUT || br);
      bre  = m_ph == 1 && (c == K_ALU || c == K_CMP || c == K_SHIFT
                           || c == K_LD || c == K_ST || br);
      aluc = m_ph == 2 && (c == K_ALU || c == K_CMP || c == K_MOV
                           || c == K_SHIFT || c == K_LD || c == K_ST || br);
      dr   = m_ph == 2 && (c == K_ALU || c == K_SHIFT || c == K_LD
                           || c == K_ST || br);
      me   = m_ph == MP && (c == K_LD || c == K_ST || c == K_IN);
      mw   = m_ph == MP && c == K_ST;
      mdr  = m_ph == MP && (c == K_LD || c == K_IN);
      gw   = m_ph == WB && (c == K_ALU || c == K_MOV || c == K_SHIFT
                            || c == K_IN || c == K_LD || c == K_LI);
      rege = m_ph == WB && c != K_ILL && c != K_HLT;
      os   = m_ph == WB && c == K_OUT;
      jmp  = m_ph == WB && m_taken;
      s2 = h && (c == K_SHIFT || c == K_LD || c == K_ST || br);
      s3 = h && br;
      s4 = h && (c == K_LD || c == K_IN);
      s5 = h && (c == K_ALU || c == K_MOV || c == K_SHIFT
                 || c == K_IN || c == K_LI);
      s6 = h && c == K_ST;
      s7 = h && c == K_IN;
      s8 = h && c == K_LI;
      return {1'b0, aluc, ar, bre, dr, mdr, ire, rege, gw, me, mw, jmp,
              s2, s3, s4, s5, s6, s7, s8, os};
   endfunction

   task automatic model_step(int c);
      if (!rst) begin
         m_ok = 1; m_busy = 0; m_wait = 0; m_halt = 0;
         m_ph = 0; m_taken = 0; m_stepm = 0;
      end else if (m_halt) begin
      end else if (!m_busy) begin
         if (bus.run || bus.step) begin
            m_busy  = 1;
            m_stepm = bus.step && !bus.run;
         end
      end else if (m_wait) begin
         if (bus.mem_rdy) begin
            m_wait = 0;
            m_ph = MP + 1;
            if (m_ph == WB) m_taken = cond_of(c);
         end
      end else if (m_ph == WB) begin
         m_ph = 0;
         m_taken = 0;
         if (c == K_HLT) begin
            m_busy = 0; m_halt = 1;
         end else if (m_stepm || !bus.run) begin
            m_busy = 0;
         end
      end else if (m_ph == MP && !bus.mem_rdy
                   && (c == K_LD || c == K_ST || c == K_IN)) begin
         m_wait = 1;
      end else begin
         m_ph++;
         if (m_ph == WB) m_taken = cond_of(c);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      int c;
      logic [15:0] ir;
      #1;
      ir = bus.instruction;
      c = cls_of(ir);
      if (m_ok) begin
         chk("ctrl", 32'(bus.ctrl), 32'(exp_ctrl(c)));
         chk("phase", 32'(bus.phase), 32'(m_ph));
         chk("busy", 32'(bus.busy), 32'(m_busy));
         chk("halted", 32'(bus.halted), 32'(m_halt));
         chk("illegal", 32'(bus.illegal),
             32'(m_busy && !m_wait && m_ph == WB && c == K_ILL));
         chk("alu_instruction", 32'(bus.alu_instruction),
             32'((ir[15:14] == 2'b11) ? {ir[15:14], ir[7:4]} : ir[15:10]));
      end
      model_step(c);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.run = 1'b0;
      bus.step = 1'b0;
      cyc();
      rst = 1'b1;
   endtask

   task automatic br_one(logic [15:0] ir, bit s, bit z, bit v, bit exp_j);
      do_reset();
      bus.instruction = ir;
      bus.S = s; bus.Z = z; bus.V = v;
      bus.run = 1'b1;
      cyc();
      bus.run = 1'b0;
      repeat (4) cyc();
      #1;
      chk("br_jump", 32'(bus.ctrl[B_JUMP]), 32'(exp_j));
      chk("br_reg_e", 32'(bus.ctrl[B_REG_E]), 32'd1);
      cyc();
   endtask

   initial begin
      int ill_cnt;
      bit bad;
      bus.run = 0; bus.step = 0; bus.mem_rdy = 1;
      bus.instruction = 16'h0000;
      bus.S = 0; bus.Z = 0; bus.C = 0; bus.V = 0;
      @(negedge clk);
      rst = 1'b0;
      cyc();
      cyc();
      #1;
      chk("rst_phase", 32'(bus.phase), 32'd0);
      chk("rst_ctrl", 32'(bus.ctrl), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);

      // ADD free-running
      rst = 1'b1;
      bus.run = 1'b1;
      bus.instruction = 16'hC000;
      cyc();
      for (int i = 0; i < NP; i++) begin
         #1;
         chk("t1_phase", 32'(bus.phase), 32'(i));
         chk("t1_genr_w", 32'(bus.ctrl[B_GENR_W]), 32'(i == WB));
         cyc();
      end
      #1;
      chk("t1_wrap", 32'(bus.phase), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd1);

      // LD with three cycles of memory wait
      do_reset();
      bus.instruction = 16'h0000;
      bus.run = 1'b1;
      cyc();
      bus.run = 1'b0;
      repeat (3) cyc();
      bus.mem_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t2_phase", 32'(bus.phase), 32'(MP));
         chk("t2_mem_e", 32'(bus.ctrl[B_MEM_E]), 32'd1);
         chk("t2_mdr_e", 32'(bus.ctrl[B_MDR_E]), 32'd1);
         cyc();
      end
      bus.mem_rdy = 1'b1;
      #1;
      chk("t2_hold", 32'(bus.ctrl[B_MEM_E]), 32'd1);
      cyc();
      #1;
      chk("t2_wb", 32'(bus.phase), 32'(WB));
      chk("t2_genr_w", 32'(bus.ctrl[B_GENR_W]), 32'd1);
      cyc();
      #1;
      chk("t2_done", 32'(bus.busy), 32'd0);

      // branches
      br_one(16'hB800, 1'b0, 1'b1, 1'b0, 1'b1);
      br_one(16'hB800, 1'b0, 1'b0, 1'b0, 1'b0);
      br_one(16'hBA00, 1'b1, 1'b0, 1'b0, 1'b1);

      // HLT
      do_reset();
      bus.instruction = 16'hC0F0;
      bus.run = 1'b1;
      cyc();
      repeat (NP) cyc();
      for (int i = 0; i < 6; i++) begin
         bus.run = 1'($urandom_range(0, 1));
         #1;
         chk("t4_halted", 32'(bus.halted), 32'd1);
         chk("t4_ctrl", 32'(bus.ctrl), 32'd0);
         cyc();
      end
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      #1;
      chk("t4_unhalt", 32'(bus.halted), 32'd0);

      // single step, then reset mid-instruction
      do_reset();
      bus.instruction = 16'hC000;
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      repeat (NP) cyc();
      #1;
      chk("t5_idle", 32'(bus.busy), 32'd0);
      chk("t5_phase", 32'(bus.phase), 32'd0);
      cyc();
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      cyc();
      cyc();
      #1;
      chk("t5_mid", 32'(bus.phase), 32'd2);
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      #1;
      chk("t5_rst_ctrl", 32'(bus.ctrl), 32'd0);
      chk("t5_rst_phase", 32'(bus.phase), 32'd0);

      // illegal encoding
      do_reset();
      bus.instruction = 16'h8800;
      bus.run = 1'b1;
      cyc();
      bus.run = 1'b0;
      ill_cnt = 0;
      bad = 0;
      for (int i = 0; i < NP + 1; i++) begin
         #1;
         ill_cnt += int'(bus.illegal);
         bad |= bus.ctrl[B_GENR_W] | bus.ctrl[B_MEM_E] | bus.ctrl[B_JUMP];
         cyc();
      end
      chk("t6_pulse", 32'(ill_cnt), 32'd1);
      chk("t6_quiet", 32'(bad), 32'd0);

      // random traffic against the model
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         rst = ($urandom_range(0, 59) != 0);
         bus.run = ($urandom_range(0, 9) < 7);
         bus.step = ($urandom_range(0, 9) == 0);
         bus.mem_rdy = ($urandom_range(0, 9) < 6);
         bus.S = 1'($urandom); bus.Z = 1'($urandom);
         bus.C = 1'($urandom); bus.V = 1'($urandom);
         if (!m_busy || (!m_wait && m_ph == 0)) begin
            case ($urandom_range(0, 3))
               0: bus.instruction = 16'($urandom);
               1: bus.instruction = {2'b11, 10'($urandom), 4'($urandom)};
               2: bus.instruction = {2'b10,
                     ($urandom_range(0, 2) == 0) ? 3'd0 :
                     ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd7,
                     3'($urandom), 8'($urandom)};
               default: bus.instruction = {1'b0, 15'($urandom)};
            endcase
         end
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
